display_source_sel: RTL and testbench

Parametrised successor to the board-display source selector. Picks one of N_CH monitored CPU values (PC, cycle count, jump/branch counters, memory data, syscall output, ...) and drives it as a registered display word. Three modes:
- manual: switch-selected channel.
- auto-scan: rotates through channels on a dwell timer.
- freeze: holds a snapshot.
Also raises a change pulse and registers the RAM address switches. Sits between the CPU statistics counters and the 7-segment driver.

---
 rtl/display_source_sel.sv | 89 ++++++++
 tb/tb_display_source_sel.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/display_source_sel.sv
// Board display source selector: picks one of N_CH monitored CPU words for the
// 7-segment driver in manual, auto-scan or freeze mode, and registers the RAM address switches.
module display_source_sel #(
  parameter int N_CH       = 8,
  parameter int WIDTH      = 32,
  parameter int SEL_W      = 3,
  parameter int DWELL      = 50000000,
  parameter int ADDR_W     = 12,
  parameter int DEFAULT_CH = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH*WIDTH-1:0] ch_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic [1:0]            mode,
  input  logic [ADDR_W-1:0]     in_addr,
  output logic [WIDTH-1:0]      chose_out,
  output logic [SEL_W-1:0]      cur_ch,
  output logic                  changed,
  output logic [ADDR_W-1:0]     RAM_addr
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] DEF_CH   = SEL_W'(DEFAULT_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);

  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_FREEZE = 2'b10;

  logic [WIDTH-1:0]  chose_q, chose_d;
  logic [SEL_W-1:0]  cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              changed_q, changed_d;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  ch_sel;
  logic              sel_ok;
  logic              frz;

  assign sel_ok = 32'(sel) < 32'(N_CH);

  always_comb begin
    cur_ch_d = cur_ch_q;
    cnt_d    = '0;
    frz      = 1'b0;
    case (mode)
      MODE_AUTO: begin
        // Counter wraps on the same edge the channel advances.
        if (cnt_q == CNT_LAST)
          cur_ch_d = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + 1'b1;
        else
          cnt_d = cnt_q + 1'b1;
      end
      MODE_FREEZE: frz = 1'b1;
      default:     cur_ch_d = sel_ok ? sel : DEF_CH;
    endcase
  end

  always_comb begin
    ch_sel = '0;
    for (int k = 0; k < N_CH; k++)
      if (cur_ch_d == SEL_W'(k)) ch_sel = ch_data[k*WIDTH +: WIDTH];
  end

  assign chose_d   = frz ? chose_q : ch_sel;
  assign changed_d = !frz && (ch_sel != chose_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chose_q   <= '0;
      cur_ch_q  <= DEF_CH;
      cnt_q     <= '0;
      changed_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      chose_q   <= chose_d;
      cur_ch_q  <= cur_ch_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
      addr_q    <= in_addr;
    end
  end

  assign chose_out = chose_q;
  assign cur_ch    = cur_ch_q;
  assign changed   = changed_q;
  assign RAM_addr  = addr_q;

endmodule

// File: tb/tb_display_source_sel.sv
// Scoreboard bench for display_source_sel: stimulus pushes model predictions,
// a monitor pops and compares one entry per clock.
module tb_display_source_sel;
  localparam int N_CH = 6, WIDTH = 32, SEL_W = 3, DWELL = 4, ADDR_W = 12, DEF = 0;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [N_CH*WIDTH-1:0] ch_data = '0;
  logic [SEL_W-1:0]      sel = '0;
  logic [1:0]            mode = '0;
  logic [ADDR_W-1:0]     in_addr = '0;
  logic [WIDTH-1:0]      chose_out;
  logic [SEL_W-1:0]      cur_ch;
  logic                  changed;
  logic [ADDR_W-1:0]     RAM_addr;

  display_source_sel #(.N_CH(N_CH), .WIDTH(WIDTH), .SEL_W(SEL_W), .DWELL(DWELL),
                       .ADDR_W(ADDR_W), .DEFAULT_CH(DEF)) dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .sel(sel), .mode(mode),
    .in_addr(in_addr), .chose_out(chose_out), .cur_ch(cur_ch),
    .changed(changed), .RAM_addr(RAM_addr));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] out;
    int          ch;
    bit          chg;
    logic [11:0] addr;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errors = 0;
  logic [31:0] chans[N_CH];

  // Reference state: displayed word, channel, cycles already spent on channel in auto.
  logic [31:0] m_out = '0;
  int          m_ch = DEF, m_cnt = 0;
  bit          m_chg = 0;
  logic [11:0] m_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and predict the state after the next rising edge.
  task automatic step(input bit rst, input logic [1:0] md, input int s, input logic [11:0] a);
    logic [31:0] old;
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < N_CH; k++) ch_data[k*WIDTH +: WIDTH] = chans[k];
    sel = SEL_W'(s); mode = md; in_addr = a; reset = rst;
    if (!rst) begin
      m_out = '0; m_ch = DEF; m_cnt = 0; m_chg = 0; m_addr = '0;
    end else begin
      old = m_out;
      if (md == 2'b10) begin
        m_chg = 0; m_cnt = 0;
      end else begin
        if (md == 2'b01) begin
          if (m_cnt == DWELL - 1) begin m_ch = (m_ch + 1) % N_CH; m_cnt = 0; end
          else m_cnt++;
        end else begin
          m_ch = (s < N_CH) ? s : DEF; m_cnt = 0;
        end
        m_out = chans[m_ch];
        m_chg = (m_out != old);
      end
      m_addr = a;
    end
    e.out = m_out; e.ch = m_ch; e.chg = m_chg; e.addr = m_addr;
    q.push_back(e);
    if (!rst) begin
      #1;
      chk("async_rst_out", chose_out, 32'h0);
      chk("async_rst_ch", 32'(cur_ch), 32'(DEF));
      chk("async_rst_chg", 32'(changed), 32'h0);
      chk("async_rst_addr", 32'(RAM_addr), 32'h0);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("chose_out", chose_out, e.out);
      chk("cur_ch", 32'(cur_ch), 32'(e.ch));
      chk("changed", 32'(changed), 32'(e.chg));
      chk("RAM_addr", 32'(RAM_addr), 32'(e.addr));
    end
  end

  initial begin
    logic [1:0] md;
    bit rst;
    for (int k = 0; k < N_CH; k++) chans[k] = '0;
    #1;
    chk("rst_out", chose_out, 32'h0);
    chk("rst_ch", 32'(cur_ch), 32'(DEF));
    chk("rst_chg", 32'(changed), 32'h0);
    chk("rst_addr", 32'(RAM_addr), 32'h0);
    step(0, 2'b00, 0, 12'h0);
    step(0, 2'b00, 0, 12'h0);

    // Manual select, then stable data.
    chans[3] = 32'h0040_0010;
    step(1, 2'b00, 3, 12'h0);
    step(1, 2'b00, 3, 12'h0);
    // Out-of-range select falls back to the default channel; mode 11 acts as manual.
    chans[0] = 32'hAAAA_0000;
    step(1, 2'b00, 6, 12'h0);
    step(1, 2'b11, 7, 12'h0);
    step(1, 2'b11, 3, 12'h0);

    // Auto-scan from channel 5 covers the wrap to 0.
    for (int k = 0; k < N_CH; k++) chans[k] = 32'h1000_0000 + 32'(k);
    step(1, 2'b00, 5, 12'h0);
    for (int i = 0; i < 14; i++) step(1, 2'b01, i, 12'h0);

    // Live data tracked while auto dwells on channel 2.
    step(1, 2'b00, 2, 12'h0);
    for (int i = 0; i < 8; i++) begin
      chans[2] = chans[2] + 1;
      chans[3] = chans[3] + 3;
      step(1, 2'b01, 0, 12'h0);
    end

    // Freeze holds while the source keeps moving, then resumes in auto.
    chans[1] = 32'h0000_1234;
    step(1, 2'b00, 1, 12'h0);
    for (int i = 0; i < 5; i++) begin
      chans[1] = chans[1] + 32'h11;
      step(1, 2'b10, 4, 12'h0);
    end
    for (int i = 0; i < 6; i++) step(1, 2'b01, 0, 12'h0);

    // Address switches, then reset mid-scan.
    step(1, 2'b01, 0, 12'hABC);
    step(1, 2'b01, 0, 12'h123);
    step(0, 2'b01, 0, 12'h456);
    step(1, 2'b01, 0, 12'h456);

    md = 2'b01;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) md = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < N_CH; k++)
        if ($urandom_range(0, 3) == 0) chans[k] = $urandom;
      step(rst, md, $urandom_range(0, 7), 12'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
